vga_pattern_gen: RTL

Parametrised VGA test-pattern generator with integrated sync timing, four selectable patterns and a per-frame scroll offset with programmable speed and direction. It sits directly behind the TinyVGA PMOD output mapping in the top level, which packs `hsync`, `vsync` and the colour channels onto `uo_out`. Unlike the previous generator, the scroll counter advances synchronously on `clk`; there is no logic clocked by `vsync`. Mode and speed are latched at frame start, so a frame never tears.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_timing.sv | 68 ++++++
 rtl/vga_pattern_gen.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and helpers for the VGA pattern generator.
package vga_pkg;

    typedef enum logic [1:0] {
        SCROLL_BARS = 2'd0,
        COLOR_BARS  = 2'd1,
        CHECKER     = 2'd2,
        GRADIENT    = 2'd3
    } mode_e;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Every pattern is built at 4 bits per channel and then truncated to the output width.
    localparam int unsigned C4_W = 4;

    typedef struct packed {
        logic [C4_W-1:0] r;
        logic [C4_W-1:0] g;
        logic [C4_W-1:0] b;
    } rgb4_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running hpos/vpos raster counters with raw sync, active-area and line/frame-end strobes.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned HW       = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned VW       = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] hpos_o,
    output logic [VW-1:0] vpos_o,
    output logic          hsync_raw_o,
    output logic          vsync_raw_o,
    output logic          active_o,
    output logic          line_end_o,
    output logic          frame_end_o
);

    localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
    localparam int unsigned HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
    localparam int unsigned VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    logic [HW-1:0] hpos_q, hpos_d;
    logic [VW-1:0] vpos_q, vpos_d;

    // Last pixel of the line and of the frame; the following clock edge wraps the counters.
    assign line_end_o  = (hpos_q == HW'(H_TOT - 1));
    assign frame_end_o = line_end_o && (vpos_q == VW'(V_TOT - 1));

    // Next raster position: hpos wraps every line, vpos advances on that wrap.
    always_comb begin
        hpos_d = hpos_q + HW'(1);
        vpos_d = vpos_q;
        if (line_end_o) begin
            hpos_d = '0;
            vpos_d = frame_end_o ? '0 : vpos_q + VW'(1);
        end
    end

    // Raster counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q <= '0;
            vpos_q <= '0;
        end else begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
        end
    end

    assign hpos_o      = hpos_q;
    assign vpos_o      = vpos_q;
    assign active_o    = (hpos_q <= HW'(H_ACTIVE - 1)) && (vpos_q <= VW'(V_ACTIVE - 1));
    assign hsync_raw_o = (hpos_q >= HW'(HS_FIRST)) && (hpos_q <= HW'(HS_LAST));
    assign vsync_raw_o = (vpos_q >= VW'(VS_FIRST)) && (vpos_q <= VW'(VS_LAST));

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: frame-latched mode, scrolling offset, pattern mux and output registers.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter bit          SYNC_NEG    = 1'b1,
    parameter int unsigned COLOR_BITS  = 2,
    parameter int unsigned SCROLL_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [2:0]            speed,
    input  logic                  dir,
    output logic                  hsync,
    output logic                  vsync,
    output logic [COLOR_BITS-1:0] r,
    output logic [COLOR_BITS-1:0] g,
    output logic [COLOR_BITS-1:0] b,
    output logic                  display_on,
    output logic                  frame_tick
);

    localparam int unsigned HW     = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned VW     = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int unsigned SW     = SCROLL_BITS;
    localparam int unsigned BAND_W = H_ACTIVE / 8;
    localparam int unsigned BCW    = cnt_width(BAND_W);

    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic          hs_raw, vs_raw, active, line_end, frame_end;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .hpos_o      (hpos),
        .vpos_o      (vpos),
        .hsync_raw_o (hs_raw),
        .vsync_raw_o (vs_raw),
        .active_o    (active),
        .line_end_o  (line_end),
        .frame_end_o (frame_end)
    );

    mode_e          mode_q, mode_d;
    logic [SW-1:0]  offset_q, offset_d;
    logic [BCW-1:0] band_cnt_q, band_cnt_d;
    logic [2:0]     band_q, band_d;

    // Frame-edge update. Speed and direction act only on this edge, so the values
    // sampled here are the frame's settings and need no separate holding register.
    always_comb begin
        mode_d   = mode_q;
        offset_d = offset_q;
        if (frame_end) begin
            mode_d   = mode_e'(mode);
            offset_d = dir ? (offset_q - SW'(speed)) : (offset_q + SW'(speed));
        end
    end

    // Colour-bar band index tracking hpos: one step every BAND_W active pixels, cleared per line.
    always_comb begin
        band_cnt_d = band_cnt_q;
        band_d     = band_q;
        if (line_end) begin
            band_cnt_d = '0;
            band_d     = '0;
        end else if (hpos <= HW'(H_ACTIVE - 1)) begin
            if (band_cnt_q == BCW'(BAND_W - 1)) begin
                band_cnt_d = '0;
                band_d     = band_q + 3'd1;
            end else begin
                band_cnt_d = band_cnt_q + BCW'(1);
            end
        end
    end

    // Frame-latched state and band counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= SCROLL_BARS;
            offset_q   <= '0;
            band_cnt_q <= '0;
            band_q     <= '0;
        end else begin
            mode_q     <= mode_d;
            offset_q   <= offset_d;
            band_cnt_q <= band_cnt_d;
            band_q     <= band_d;
        end
    end

    logic [SW-1:0] mx, my, vx;
    logic [2:0]    band_k;
    rgb4_t         pix;

    // Pattern mux at 4 bits per channel; black outside the active area.
    always_comb begin
        vx     = SW'(vpos);
        mx     = offset_q + SW'(hpos);
        my     = offset_q + vx;
        band_k = 3'd7 - band_q;
        pix    = '0;
        if (active) begin
            case (mode_q)
                SCROLL_BARS: begin
                    pix.r = {mx[5], vx[2], 2'b00};
                    pix.g = {mx[6], vx[2], 2'b00};
                    pix.b = {mx[7], vx[5], 2'b00};
                end
                COLOR_BARS: begin
                    pix.r = {4{band_k[2]}};
                    pix.g = {4{band_k[1]}};
                    pix.b = {4{band_k[0]}};
                end
                CHECKER: begin
                    pix.r = {4{mx[5] ^ my[5]}};
                    pix.g = {4{mx[5] ^ my[5]}};
                    pix.b = {4{mx[5] ^ my[5]}};
                end
                GRADIENT: begin
                    pix.r = mx[8:5];
                    pix.g = vx[8:5];
                    pix.b = offset_q[SW-1 -: 4];
                end
                default: pix = '0;
            endcase
        end
    end

    logic                  hsync_q, vsync_q, display_on_q, frame_tick_q;
    logic [COLOR_BITS-1:0] r_q, g_q, b_q;

    // Output stage: everything delayed by one clock so syncs, colour and strobes stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q      <= SYNC_NEG;
            vsync_q      <= SYNC_NEG;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            display_on_q <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            hsync_q      <= hs_raw ^ SYNC_NEG;
            vsync_q      <= vs_raw ^ SYNC_NEG;
            r_q          <= pix.r[C4_W-1 -: COLOR_BITS];
            g_q          <= pix.g[C4_W-1 -: COLOR_BITS];
            b_q          <= pix.b[C4_W-1 -: COLOR_BITS];
            display_on_q <= active;
            frame_tick_q <= (hpos == '0) && (vpos == '0);
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign r          = r_q;
    assign g          = g_q;
    assign b          = b_q;
    assign display_on = display_on_q;
    assign frame_tick = frame_tick_q;

endmodule
